// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the multiplexed 7-segment display: digit geometry and
// active-high {g,f,e,d,c,b,a} segment patterns.
package bcd_display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned BCD_W      = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; non-decimal
// nibbles show an 'E'.
module bcd_to_7seg
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_E;
        case (nibble)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures a 5-digit BCD word and scans it onto a common-anode multiplexed
// 7-segment display with optional leading-zero blanking.
module bcd_display_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned NUM_DIGITS  = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_input,
    input  logic                    blank_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segments,
    output logic                    display_valid
);

    import bcd_display_scan_pkg::*;

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);

    logic [BCD_W*NUM_DIGITS-1:0] data_reg;
    logic [PRESC_W-1:0]          presc;
    logic [2:0]                  digit_idx;
    logic [2:0]                  idx_next;
    logic                        tick;
    logic [NUM_DIGITS-1:0]       lead_zero;
    logic [BCD_W-1:0]            sel_nibble;
    logic [6:0]                  sel_pattern;
    logic [NUM_DIGITS-1:0]       anode_next;
    logic [6:0]                  segments_next;

    assign tick     = (presc == PRESC_W'(REFRESH_DIV - 1));
    assign idx_next = (digit_idx >= 3'(NUM_DIGITS - 1)) ? '0 : digit_idx + 3'd1;

    // lead_zero[i] is set when nibble i and every more significant nibble are zero.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            all_zero = all_zero && (data_reg[BCD_W*(NUM_DIGITS-1-k) +: BCD_W] == '0);
            lead_zero[NUM_DIGITS-1-k] = all_zero;
        end
    end

    always_comb begin
        sel_nibble = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == 3'(i)) begin
                sel_nibble = data_reg[BCD_W*i +: BCD_W];
            end
        end
    end

    bcd_to_7seg u_decode (
        .nibble  (sel_nibble),
        .pattern (sel_pattern)
    );

    // Out-of-range indices match no digit, so they fall through to all-blank.
    always_comb begin
        anode_next    = '1;
        segments_next = ~SEG_BLANK;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (display_valid && digit_idx == 3'(i) &&
                !(blank_en && i != 0 && lead_zero[i])) begin
                anode_next[i] = 1'b0;
                segments_next = ~sel_pattern;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_reg      <= '0;
            presc         <= '0;
            digit_idx     <= '0;
            display_valid <= 1'b0;
            anode         <= '1;
            segments      <= '1;
        end else begin
            if (load) begin
                data_reg      <= bcd_input;
                display_valid <= 1'b1;
            end
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                digit_idx <= idx_next;
            end
            anode    <= anode_next;
            segments <= segments_next;
        end
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the binary-to-BCD converter's 5-digit BCD result.
- Captures the BCD value on the converter's done pulse and drives a time-multiplexed 5-digit common-anode 7-segment display on the FPGA board.
- Provides a refresh prescaler, a digit scan counter, per-digit segment decoding, optional leading-zero blanking and an error glyph for non-decimal nibbles.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (1 kHz per digit at 50 MHz); legal range 2..2^20.
- NUM_DIGITS, 5, fixed digit count matching the 20-bit BCD word; not intended to be overridden.

Ports:
- clock  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-low reset
- load  input  1  one-cycle pulse (converter done); captures bcd_input
- bcd_input  input  20  {ten_thousands, thousands, hundreds, tens, units}, 4 bits each
- blank_en  input  1  1 = blank leading zeros
- anode  output  5  digit enables, active-low; bit i = digit i, with bit 0 = units
- segments  output  7  {g,f,e,d,c,b,a}, active-low
- display_valid  output  1  high once a value has been captured since reset

Behaviour:
- Reset (reset=0 at a clock edge):
  - data register = 0, prescaler = 0, digit index = 0, display_valid = 0.
  - anode = 5'b11111, segments = 7'b1111111.
  - Reset asserted mid-scan or mid-load wins over every other event.
- Capture:
  - When load=1 at an edge, the data register takes bcd_input and display_valid goes to 1.
  - display_valid stays 1 until the next reset.
  - Back-to-back loads: the last one wins.
  - load while display_valid=1 simply overwrites the data register.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler == REFRESH_DIV-1).
  - On tick, the digit index advances 0,1,2,3,4 and then wraps to 0.
  - Each index is therefore held for exactly REFRESH_DIV cycles.
  - The prescaler and index run even while display_valid=0.
- Output registers:
  - anode and segments are registered.
  - They reflect the digit index and data register contents of the previous cycle, i.e. one cycle of latency.
- Simultaneous load and tick:
  - Both take effect at the same edge.
  - The newly selected digit is displayed from the newly loaded data.
- Digit drive:
  - If display_valid=0, the digit is blanked: anode = 11111 and segments = 1111111.
  - Otherwise anode has only bit[index] low.
- Leading-zero blanking:
  - Digit i (i ≥ 1) is blanked when blank_en=1 and all nibbles i..4 equal 0.
  - Blanked means its anode bit stays high and segments = 1111111.
  - The units digit is never blanked, so the value 0 displays "0".
  - blank_en is sampled combinationally each cycle and is not latched.
- Segment encoding (active-high before inversion, as {g..a}):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - nibbles A–F → 'E' = 0x79
  - The output is the bitwise inverse of the encoding.
- Widths:
  - Prescaler width = clog2(REFRESH_DIV).
  - Digit index = 3 bits; values 5–7 are unreachable and decode to all-blank if ever entered.

Decomposition:
- Shared package holds:
  - the segment constants SEG_0..SEG_9 and SEG_E
  - SEG_BLANK
  - NUM_DIGITS = 5
  - the BCD digit width 4
- One combinational sub-module, bcd_to_7seg: 4-bit nibble in, 7-bit active-high pattern out, with 'E' for nibbles above 9.
- Scan control, prescaler, blanking logic and output registers stay in the top block.

Test Plan (REFRESH_DIV=4):
- Reset: hold reset=0 for 3 cycles → anode=11111, segments=1111111, display_valid=0. Release reset, no load for 40 cycles → outputs stay blank.
- Load 20'h01234 with blank_en=0 → display_valid=1. Each digit is held 4 cycles with the following anode/segments:
  - anode 11110 / segments ~0x66
  - anode 11101 / segments ~0x4F
  - anode 11011 / segments ~0x5B
  - anode 10111 / segments ~0x06
  - anode 01111 / segments ~0x3F
  - then the scan wraps back to 11110.
- blank_en=1:
  - Load 20'h00007 → only the units digit lights (~0x07); slots 1–4 show anode 11111.
  - Load 20'h00000 → the units digit shows ~0x3F.
  - Load 20'h10005 → no digit is blanked.
- Load 20'h000C0 → the tens slot shows ~0x79 ('E') and the units slot shows ~0x3F.
- Apply load coincident with tick as the index goes 1→2, changing hundreds from 2 to 9 → the first cycle of the hundreds slot shows ~0x6F.
- Assert reset=0 for one cycle mid-scan at index 3 → next cycle outputs are blank and display_valid=0. After release, the scan restarts at index 0.
